sysid_checker: RTL and testbench
================================

// Module: sysid_checker
// PURPOSE
//   Avalon-MM read master that sits directly upstream of the system-ID slave.
//   After reset, or on request, it reads word 0 (system ID) and word 1 (build timestamp).
//   It compares both words against the values this build expects and reports the results.
//   Its status outputs gate host/DMA bring-up, so a stale or mismatched FPGA image is caught before OCT acquisition starts.
// PARAMETERS
//   EXPECTED_ID        32'd532098244   value required at address 0
//   EXPECTED_TIMESTAMP 32'd1308857516  value required at address 1
//   TIMEOUT_CYCLES     255             max cycles per read (command + response) before abort; range 1..65535
//   AUTO_START         1               1: launch a check automatically after reset release
// PORTS
//   clk            in   1   system clock
//   reset_n        in   1   asynchronous active-low reset
//   start          in   1   pulse: begin a check (honoured only in IDLE/DONE)
//   av_address     out  1   0 = ID word, 1 = timestamp word
//   av_read        out  1   read command
//   av_waitrequest in   1   slave/fabric stall
//   av_readdata    in   32  read data
//   av_readdatavalid in 1   read response strobe
//   busy           out  1   check in progress
//   done           out  1   sticky: last check finished (pass, fail or timeout)
//   id_ok          out  1   captured ID == EXPECTED_ID
//   ts_ok          out  1   captured timestamp == EXPECTED_TIMESTAMP
//   timeout        out  1   last check aborted on timeout
//   id_value       out  32  captured ID word
//   ts_value       out  32  captured timestamp word
// BEHAVIOUR
//   - Reset: state IDLE; all outputs 0, including id_value/ts_value; timeout counter 0.
//   - FSM states: IDLE, CMD_ID, RSP_ID, CMD_TS, RSP_TS, DONE.
//   - IDLE -> CMD_ID on start=1, or on the first clock after reset release when AUTO_START=1.
//   - DONE -> CMD_ID on start=1.
//   - On launch:
//       - done, id_ok, ts_ok and timeout clear.
//       - busy=1 from the first CMD_ID cycle until the DONE entry cycle (exclusive).
//   - CMD_x drives av_read=1 with av_address=0 (ID) or 1 (TS), held stable while av_waitrequest=1.
//   - A command is accepted in a cycle with av_read=1 and av_waitrequest=0.
//   - On acceptance, go to RSP_x. av_read=0 in the next cycle.
//   - RSP_x: on av_readdatavalid=1, capture av_readdata into id_value/ts_value.
//       - RSP_ID then goes to CMD_TS.
//       - RSP_TS then goes to DONE.
//   - av_readdatavalid in any other state (including the accept cycle) is ignored.
//   - Only one read is ever outstanding.
//   - Compare is registered:
//       - id_ok/ts_ok are set in the DONE entry cycle, together with done=1 and busy=0.
//       - Both hold until the next launch.
//   - Timeout counter (16 b):
//       - Cleared on entry to CMD_ID and CMD_TS.
//       - Increments in every CMD/RSP cycle.
//       - When it reaches TIMEOUT_CYCLES before the response: go to DONE with timeout=1.
//       - On timeout: av_read=0, and id_ok/ts_ok=0 for both words.
//       - Words already captured remain visible on id_value/ts_value.
//   - start while busy=1 is ignored; no queuing.
//   - Response and timeout in the same cycle: the response wins.
//   - Reset asserted mid-check: immediate return to reset values; av_read drops asynchronously.
//   - Zero-wait slave with 1-cycle response latency:
//       - Timeline: start@T -> CMD_ID@T+1 -> RSP_ID@T+2 (valid) -> CMD_TS@T+3 -> RSP_TS@T+4 (valid) -> done=1@T+5.
//       - Total: 5 cycles from start to done.
// TESTING
//   1. AUTO_START=1, zero-wait slave, latency 1, returns 532098244 / 1308857516:
//      -> av_address 0 then 1.
//      -> done=1, id_ok=1, ts_ok=1, timeout=0 exactly 5 cycles after reset release + 1.
//   2. Slave returns timestamp 32'h0 -> done=1, id_ok=1, ts_ok=0, ts_value=0.
//   3. av_waitrequest high for 3 cycles on the ID read:
//      -> av_read/av_address stable for 4 cycles, single acceptance, check passes.
//   4. Slave never asserts readdatavalid, TIMEOUT_CYCLES=10:
//      -> DONE with timeout=1 after 10 cycles, id_ok=ts_ok=0, av_read=0.
//   5. reset_n pulsed low during RSP_TS -> all outputs 0 at once.
//      -> AUTO_START relaunches and the check then passes.
//   6. start pulsed during CMD_TS -> ignored (one ID read, one TS read total).
//      -> start in DONE relaunches, clearing done for that run.

Source files
------------

// File: rtl/sysid_checker.sv
// rtl/sysid_checker.sv - Avalon-MM read master that checks system ID and build timestamp words.
// Reads word 0 then word 1, compares against build constants and reports sticky status.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd532098244,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1308857516,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        av_address,
    output logic        av_read,
    input  logic        av_waitrequest,
    input  logic [31:0] av_readdata,
    input  logic        av_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD_ID = 3'd1;
    localparam logic [2:0] S_RSP_ID = 3'd2;
    localparam logic [2:0] S_CMD_TS = 3'd3;
    localparam logic [2:0] S_RSP_TS = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Last counter value at which a read may still complete; the next cycle would exceed the budget.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [15:0] tmo_cnt;
    logic        auto_pending;
    logic        in_cmd;
    logic        in_rsp;
    logic        accept;
    logic        resp;
    logic        expire;
    logic        launch;
    logic        enter_done;
    logic        enter_cmd;

    assign in_cmd = (state == S_CMD_ID) || (state == S_CMD_TS);
    assign in_rsp = (state == S_RSP_ID) || (state == S_RSP_TS);
    assign accept = in_cmd && !av_waitrequest;
    assign resp   = in_rsp && av_readdatavalid;

    // A response arriving in the last allowed cycle wins over the timeout.
    assign expire = (in_cmd || in_rsp) && (tmo_cnt == TMO_LAST) && !resp;

    assign launch = ((state == S_IDLE) && (start || auto_pending)) ||
                    ((state == S_DONE) && start);

    assign av_read    = in_cmd;
    assign av_address = (state == S_CMD_TS);
    assign busy       = in_cmd || in_rsp;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (launch) state_nx = S_CMD_ID;
            end
            S_CMD_ID: begin
                if (expire)      state_nx = S_DONE;
                else if (accept) state_nx = S_RSP_ID;
            end
            S_RSP_ID: begin
                if (resp)        state_nx = S_CMD_TS;
                else if (expire) state_nx = S_DONE;
            end
            S_CMD_TS: begin
                if (expire)      state_nx = S_DONE;
                else if (accept) state_nx = S_RSP_TS;
            end
            S_RSP_TS: begin
                if (resp || expire) state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign enter_done = (state != S_DONE) && (state_nx == S_DONE);
    assign enter_cmd  = (state_nx != state) &&
                        ((state_nx == S_CMD_ID) || (state_nx == S_CMD_TS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            tmo_cnt      <= 16'd0;
            auto_pending <= AUTO_START;
        end else begin
            state        <= state_nx;
            auto_pending <= 1'b0;
            if (enter_cmd)
                tmo_cnt <= 16'd0;
            else if (in_cmd || in_rsp)
                tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_value <= 32'd0;
            ts_value <= 32'd0;
        end else begin
            if ((state == S_RSP_ID) && av_readdatavalid)
                id_value <= av_readdata;
            if ((state == S_RSP_TS) && av_readdatavalid)
                ts_value <= av_readdata;
        end
    end

    // Timestamp is compared straight off the bus since it lands in the same edge as DONE entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done    <= 1'b0;
            id_ok   <= 1'b0;
            ts_ok   <= 1'b0;
            timeout <= 1'b0;
        end else if (launch) begin
            done    <= 1'b0;
            id_ok   <= 1'b0;
            ts_ok   <= 1'b0;
            timeout <= 1'b0;
        end else if (enter_done) begin
            done    <= 1'b1;
            timeout <= expire;
            id_ok   <= !expire && (id_value == EXPECTED_ID);
            ts_ok   <= !expire && (av_readdata == EXPECTED_TIMESTAMP);
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// tb/tb_sysid_checker.sv - Self-checking bench for sysid_checker with an Avalon slave model.
// Table vectors, hand-written corner sequences and randomized runs against a timing model.
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd532098244;
    localparam logic [31:0] EXP_TS = 32'd1308857516;
    localparam int          TMO    = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        av_address;
    logic        av_read;
    logic        av_waitrequest;
    logic [31:0] av_readdata;
    logic        av_readdatavalid;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    sysid_checker #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .TIMEOUT_CYCLES     (TMO),
        .AUTO_START         (1'b1)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .av_address       (av_address),
        .av_read          (av_read),
        .av_waitrequest   (av_waitrequest),
        .av_readdata      (av_readdata),
        .av_readdatavalid (av_readdatavalid),
        .busy             (busy),
        .done             (done),
        .id_ok            (id_ok),
        .ts_ok            (ts_ok),
        .timeout          (timeout),
        .id_value         (id_value),
        .ts_value         (ts_value)
    );

    always #5 clk = ~clk;

    // lat = 0 means the slave never answers that read.
    typedef struct {
        int          mode;
        int          w_id;
        int          l_id;
        int          w_ts;
        int          l_ts;
        logic [31:0] d_id;
        logic [31:0] d_ts;
        bit          spur;
    } cfg_t;

    typedef struct {
        int          tick;
        bit          id_ok;
        bit          ts_ok;
        bit          to;
        logic [31:0] idv;
        logic [31:0] tsv;
        int          rd_id;
        int          rd_ts;
    } exp_t;

    typedef struct {
        cfg_t c;
        exp_t e;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    int          cfg_wait [2];
    int          cfg_lat  [2];
    logic [31:0] cfg_data [2];
    int          rd_cnt   [2];
    int          wcnt;
    bit          acc_last;
    bit          pend;
    int          cd;
    int          paddr;
    bit          spur_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic slave_clear();
        wcnt = 0; acc_last = 0; pend = 0; cd = 0; paddr = 0;
        rd_cnt[0] = 0; rd_cnt[1] = 0;
    endtask

    // Decides the slave inputs for the coming edge from what the master shows in this cycle.
    task automatic slave_drive();
        av_readdatavalid = 1'b0;
        av_readdata      = $urandom;
        av_waitrequest   = 1'b0;
        if (acc_last) begin
            pend = 1; cd = cfg_lat[paddr]; acc_last = 0;
        end
        if (pend && cd != 0) begin
            if (cd == 1) begin
                av_readdatavalid = 1'b1;
                av_readdata      = cfg_data[paddr];
                pend             = 0;
            end else begin
                cd--;
            end
        end
        if (av_read) begin
            rd_cnt[av_address]++;
            if (wcnt < cfg_wait[av_address]) begin
                av_waitrequest = 1'b1;
                wcnt++;
            end else begin
                acc_last = 1; paddr = int'(av_address); wcnt = 0;
            end
            if (spur_en && !av_readdatavalid && ($urandom_range(0, 1) == 1)) begin
                av_readdatavalid = 1'b1;
                av_readdata      = $urandom;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        slave_drive();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".rst_flags"}, {26'd0, busy, done, id_ok, ts_ok, timeout, av_read}, 32'd0);
        chk({tag, ".rst_id"}, id_value, 32'd0);
        chk({tag, ".rst_ts"}, ts_value, 32'd0);
    endtask

    task automatic run_check(input cfg_t c, input exp_t e, input int poke, input string tag);
        slave_clear();
        cfg_wait[0] = c.w_id; cfg_lat[0] = c.l_id; cfg_data[0] = c.d_id;
        cfg_wait[1] = c.w_ts; cfg_lat[1] = c.l_ts; cfg_data[1] = c.d_ts;
        spur_en = c.spur;
        tick();
        if (c.mode == 1) begin
            reset_n = 1'b0;
            tick();
            tick();
            chk_reset_state(tag);
            slave_clear();
            reset_n = 1'b1;
        end else begin
            start = 1'b1;
        end
        for (int k = 1; k <= e.tick; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            if (k == poke + 1) start = 1'b0;
            if (k == poke) start = 1'b1;
            if (k < e.tick) begin
                chk({tag, ".busy_done"}, {30'd0, busy, done}, 32'd2);
            end else begin
                chk({tag, ".end_flags"}, {27'd0, busy, done, id_ok, ts_ok, timeout},
                    {27'd0, 1'b0, 1'b1, e.id_ok, e.ts_ok, e.to});
                chk({tag, ".av_read"}, {31'd0, av_read}, 32'd0);
                chk({tag, ".id_value"}, id_value, e.idv);
                chk({tag, ".ts_value"}, ts_value, e.tsv);
                chk({tag, ".rd_id_cycles"}, rd_cnt[0], e.rd_id);
                chk({tag, ".rd_ts_cycles"}, rd_cnt[1], e.rd_ts);
            end
        end
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk({tag, ".sticky"}, {29'd0, busy, done, av_read}, 32'd2);
        end
    endtask

    // Cycle model: a read lasts (wait+1) command cycles plus lat response cycles and must fit in TMO.
    function automatic exp_t model(input cfg_t c, input logic [31:0] pid, input logic [31:0] pts);
        exp_t e;
        int   d_id;
        int   d_ts;
        d_id    = c.w_id + 1 + c.l_id;
        d_ts    = c.w_ts + 1 + c.l_ts;
        e.rd_id = c.w_id + 1;
        e.id_ok = 0; e.ts_ok = 0; e.to = 1;
        if (c.l_id == 0 || d_id > TMO) begin
            e.tick = 1 + TMO; e.idv = pid; e.tsv = pts; e.rd_ts = 0;
        end else begin
            e.idv   = c.d_id;
            e.rd_ts = c.w_ts + 1;
            if (c.l_ts == 0 || d_ts > TMO) begin
                e.tick = 1 + d_id + TMO; e.tsv = pts;
            end else begin
                e.tick  = 1 + d_id + d_ts;
                e.tsv   = c.d_ts;
                e.to    = 0;
                e.id_ok = (c.d_id == EXP_ID);
                e.ts_ok = (c.d_ts == EXP_TS);
            end
        end
        return e;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [8];
        cfg_t        c;
        exp_t        e;
        logic [31:0] pid;
        logic [31:0] pts;

        vecs[0] = '{'{1, 0, 1, 0, 1, EXP_ID, EXP_TS, 0},           '{5, 1, 1, 0, EXP_ID, EXP_TS, 1, 1}};
        vecs[1] = '{'{0, 0, 1, 0, 1, EXP_ID, 32'h0, 0},            '{5, 1, 0, 0, EXP_ID, 32'h0, 1, 1}};
        vecs[2] = '{'{0, 3, 1, 0, 1, EXP_ID, EXP_TS, 0},           '{8, 1, 1, 0, EXP_ID, EXP_TS, 4, 1}};
        vecs[3] = '{'{0, 0, 0, 0, 1, EXP_ID, EXP_TS, 0},           '{11, 0, 0, 1, EXP_ID, EXP_TS, 1, 0}};
        vecs[4] = '{'{0, 0, 9, 0, 1, EXP_ID, EXP_TS, 0},           '{13, 1, 1, 0, EXP_ID, EXP_TS, 1, 1}};
        vecs[5] = '{'{0, 0, 1, 0, 10, 32'hDEADBEEF, 32'h0, 0},     '{13, 0, 0, 1, 32'hDEADBEEF, EXP_TS, 1, 1}};
        vecs[6] = '{'{0, 0, 1, 2, 1, EXP_ID ^ 32'h1, EXP_TS, 1},   '{7, 0, 1, 0, EXP_ID ^ 32'h1, EXP_TS, 1, 3}};
        vecs[7] = '{'{0, 0, 2, 2, 3, EXP_ID, EXP_TS, 0},           '{10, 1, 1, 0, EXP_ID, EXP_TS, 1, 3}};

        reset_n          = 1'b0;
        start            = 1'b0;
        av_waitrequest   = 1'b0;
        av_readdata      = 32'd0;
        av_readdatavalid = 1'b0;
        spur_en          = 0;
        for (int i = 0; i < 2; i++) begin
            cfg_wait[i] = 0; cfg_lat[i] = 1; cfg_data[i] = 32'd0;
        end
        slave_clear();

        for (int i = 0; i < 8; i++)
            run_check(vecs[i].c, vecs[i].e, 0, $sformatf("vec%0d", i));

        // Reset in the middle of the timestamp response, then auto relaunch.
        c = '{0, 0, 1, 0, 1, 32'h12345678, EXP_TS, 0};
        slave_clear();
        cfg_wait[0] = 0; cfg_lat[0] = 1; cfg_data[0] = c.d_id;
        cfg_wait[1] = 0; cfg_lat[1] = 1; cfg_data[1] = c.d_ts;
        spur_en = 0;
        tick();
        start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            start = 1'b0;
        end
        chk("midrst.pre_id", id_value, 32'h12345678);
        chk("midrst.pre_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk_reset_state("midrst");
        run_check('{1, 0, 1, 0, 1, EXP_ID, EXP_TS, 0}, '{5, 1, 1, 0, EXP_ID, EXP_TS, 1, 1}, 0, "relaunch");

        // Start during CMD_TS is ignored; start in DONE relaunches.
        run_check('{0, 0, 1, 0, 1, EXP_ID, EXP_TS, 0}, '{5, 1, 1, 0, EXP_ID, EXP_TS, 1, 1}, 3, "busy_start");
        run_check('{0, 0, 1, 0, 1, EXP_ID, EXP_TS, 0}, '{5, 1, 1, 0, EXP_ID, EXP_TS, 1, 1}, 0, "done_start");

        pid = EXP_ID;
        pts = EXP_TS;
        for (int r = 0; r < 40; r++) begin
            c.mode = 0;
            c.w_id = $urandom_range(0, 3);
            c.l_id = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 7);
            c.w_ts = $urandom_range(0, 3);
            c.l_ts = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 7);
            c.d_id = ($urandom_range(0, 2) != 0) ? EXP_ID : $urandom;
            c.d_ts = ($urandom_range(0, 2) != 0) ? EXP_TS : $urandom;
            c.spur = ($urandom_range(0, 1) == 1);
            e = model(c, pid, pts);
            run_check(c, e, 0, $sformatf("rnd%0d", r));
            pid = e.idv;
            pts = e.tsv;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
